// File: rtl/choose_grid_select.sv
// ---------------------------------------------------------------------------
// choose_grid_select : two-player character-select grid controller with
// per-player lock/cancel and a one-cycle choose_done pulse.
// Optional build macro: CHOOSE_GRID_WRAP_EN (edge moves wrap instead of saturate)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module choose_grid_select #(
  parameter int COLS   = 4,
  parameter int ROWS   = 2,
  parameter int ID_W   = 8,
  parameter int STAT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        scene_state,
  input  logic [4:0]        p1_key,
  input  logic [4:0]        p2_key,
  output logic [ID_W-1:0]   p1_id,
  output logic [ID_W-1:0]   p2_id,
  output logic [STAT_W-1:0] p1_hp,
  output logic [STAT_W-1:0] p1_speed,
  output logic [STAT_W-1:0] p1_dmg1,
  output logic [STAT_W-1:0] p1_dmg2,
  output logic [STAT_W-1:0] p1_dmg3,
  output logic [STAT_W-1:0] p2_hp,
  output logic [STAT_W-1:0] p2_speed,
  output logic [STAT_W-1:0] p2_dmg1,
  output logic [STAT_W-1:0] p2_dmg2,
  output logic [STAT_W-1:0] p2_dmg3,
  output logic              p1_locked,
  output logic              p2_locked,
  output logic              choose_done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  localparam logic [3:0] SCENE_START  = 4'd1;
  localparam logic [3:0] SCENE_CHOOSE = 4'd2;

  // key vector layout {U,D,L,R,C}
  localparam logic [4:0] KEY_U = 5'b10000;
  localparam logic [4:0] KEY_D = 5'b01000;
  localparam logic [4:0] KEY_L = 5'b00100;
  localparam logic [4:0] KEY_R = 5'b00010;
  localparam logic [4:0] KEY_C = 5'b00001;

  localparam int HP_TAB    [8] = '{50, 60, 70, 90, 100, 120, 150, 160};
  localparam int SPEED_TAB [8] = '{250, 225, 200, 175, 150, 125, 100, 75};

  typedef enum logic [1:0] {
    ST_BROWSE = 2'd0,
    ST_LOCKED = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t             st_q  [2];
  state_t             st_d  [2];
  logic [RW-1:0]      row_q [2];
  logic [RW-1:0]      row_d [2];
  logic [CW-1:0]      col_q [2];
  logic [CW-1:0]      col_d [2];
  logic [ID_W-1:0]    id_q  [2];
  logic [ID_W-1:0]    id_d  [2];
  logic [STAT_W-1:0]  hp_q  [2];
  logic [STAT_W-1:0]  hp_d  [2];
  logic [STAT_W-1:0]  spd_q [2];
  logic [STAT_W-1:0]  spd_d [2];
  logic [4:0]         key_in[2];
  logic               done_q;
  logic               done_d;

  assign key_in[0] = p1_key;
  assign key_in[1] = p2_key;

  function automatic logic [ID_W-1:0] id_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return ID_W'(r) * ID_W'(COLS) + ID_W'(c) + ID_W'(1);
  endfunction

  // stat table repeats every 8 ids
  function automatic logic [2:0] tab_idx(input logic [ID_W-1:0] id);
    logic [ID_W-1:0] z;
    z = id - ID_W'(1);
    return 3'(z);
  endfunction

  function automatic logic [STAT_W-1:0] hp_of(input logic [ID_W-1:0] id);
    return STAT_W'(HP_TAB[tab_idx(id)]);
  endfunction

  function automatic logic [STAT_W-1:0] speed_of(input logic [ID_W-1:0] id);
    return STAT_W'(SPEED_TAB[tab_idx(id)]);
  endfunction

  function automatic logic one_hot(input logic [4:0] k);
    return (k != 5'd0) && ((k & (k - 5'd1)) == 5'd0);
  endfunction

  function automatic logic [RW-1:0] row_dec(input logic [RW-1:0] r);
    logic [RW-1:0] res;
    if (r == '0) begin
`ifdef CHOOSE_GRID_WRAP_EN
      res = ROW_MAX;
`else
      res = r;
`endif
    end else begin
      res = r - 1'b1;
    end
    return res;
  endfunction

  function automatic logic [RW-1:0] row_inc(input logic [RW-1:0] r);
    logic [RW-1:0] res;
    if (r == ROW_MAX) begin
`ifdef CHOOSE_GRID_WRAP_EN
      res = '0;
`else
      res = r;
`endif
    end else begin
      res = r + 1'b1;
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] col_dec(input logic [CW-1:0] c);
    logic [CW-1:0] res;
    if (c == '0) begin
`ifdef CHOOSE_GRID_WRAP_EN
      res = COL_MAX;
`else
      res = c;
`endif
    end else begin
      res = c - 1'b1;
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] col_inc(input logic [CW-1:0] c);
    logic [CW-1:0] res;
    if (c == COL_MAX) begin
`ifdef CHOOSE_GRID_WRAP_EN
      res = '0;
`else
      res = c;
`endif
    end else begin
      res = c + 1'b1;
    end
    return res;
  endfunction

  always_comb begin
    done_d = 1'b0;
    for (int p = 0; p < 2; p++) begin
      st_d[p]  = st_q[p];
      row_d[p] = row_q[p];
      col_d[p] = col_q[p];
      if (scene_state == SCENE_START) begin
        st_d[p]  = ST_BROWSE;
        row_d[p] = (p == 0) ? '0 : ROW_MAX;
        col_d[p] = (p == 0) ? '0 : COL_MAX;
      end else if (scene_state == SCENE_CHOOSE) begin
        case (st_q[p])
          ST_BROWSE: begin
            if (one_hot(key_in[p])) begin
              case (key_in[p])
                KEY_U:   row_d[p] = row_dec(row_q[p]);
                KEY_D:   row_d[p] = row_inc(row_q[p]);
                KEY_L:   col_d[p] = col_dec(col_q[p]);
                KEY_R:   col_d[p] = col_inc(col_q[p]);
                default: st_d[p]  = ST_LOCKED;
              endcase
            end
          end
          ST_LOCKED: begin
            if (key_in[p] == KEY_C) st_d[p] = ST_BROWSE;
          end
          default: ;
        endcase
      end
    end

    // second lock taking effect moves both players into DONE together
    if ((scene_state == SCENE_CHOOSE) && (st_d[0] == ST_LOCKED) && (st_d[1] == ST_LOCKED)) begin
      st_d[0] = ST_DONE;
      st_d[1] = ST_DONE;
      done_d  = 1'b1;
    end

    for (int p = 0; p < 2; p++) begin
      id_d[p]  = id_of(row_d[p], col_d[p]);
      hp_d[p]  = hp_of(id_d[p]);
      spd_d[p] = speed_of(id_d[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        st_q[p]  <= ST_BROWSE;
        row_q[p] <= (p == 0) ? '0 : ROW_MAX;
        col_q[p] <= (p == 0) ? '0 : COL_MAX;
        id_q[p]  <= (p == 0) ? id_of('0, '0) : id_of(ROW_MAX, COL_MAX);
        hp_q[p]  <= (p == 0) ? hp_of(id_of('0, '0)) : hp_of(id_of(ROW_MAX, COL_MAX));
        spd_q[p] <= (p == 0) ? speed_of(id_of('0, '0)) : speed_of(id_of(ROW_MAX, COL_MAX));
      end
      done_q <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        st_q[p]  <= st_d[p];
        row_q[p] <= row_d[p];
        col_q[p] <= col_d[p];
        id_q[p]  <= id_d[p];
        hp_q[p]  <= hp_d[p];
        spd_q[p] <= spd_d[p];
      end
      done_q <= done_d;
    end
  end

  assign p1_id       = id_q[0];
  assign p2_id       = id_q[1];
  assign p1_hp       = hp_q[0];
  assign p2_hp       = hp_q[1];
  assign p1_speed    = spd_q[0];
  assign p2_speed    = spd_q[1];
  assign p1_dmg1     = STAT_W'(30);
  assign p1_dmg2     = STAT_W'(40);
  assign p1_dmg3     = STAT_W'(50);
  assign p2_dmg1     = STAT_W'(30);
  assign p2_dmg2     = STAT_W'(40);
  assign p2_dmg3     = STAT_W'(50);
  assign p1_locked   = (st_q[0] != ST_BROWSE);
  assign p2_locked   = (st_q[1] != ST_BROWSE);
  assign choose_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_choose_grid_select.sv
// ---------------------------------------------------------------------------
// tb_choose_grid_select : directed vector bench for choose_grid_select (4x2 grid).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_choose_grid_select;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] scene_state;
  logic [4:0] p1_key, p2_key;
  logic [7:0] p1_id, p2_id;
  logic [7:0] p1_hp, p1_speed, p1_dmg1, p1_dmg2, p1_dmg3;
  logic [7:0] p2_hp, p2_speed, p2_dmg1, p2_dmg2, p2_dmg3;
  logic       p1_locked, p2_locked, choose_done;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef CHOOSE_GRID_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [4:0] KU = 5'b10000, KD = 5'b01000, KL = 5'b00100, KR = 5'b00010, KC = 5'b00001;

  int hp_tab  [8] = '{50, 60, 70, 90, 100, 120, 150, 160};
  int spd_tab [8] = '{250, 225, 200, 175, 150, 125, 100, 75};

  typedef struct {
    logic [3:0]  sc;
    logic [4:0]  k1;
    logic [4:0]  k2;
    logic [50:0] exp;
  } vec_t;

  vec_t vecs[$];

  choose_grid_select #(.COLS(4), .ROWS(2), .ID_W(8), .STAT_W(8)) dut (
    .clk(clk), .reset(reset), .scene_state(scene_state),
    .p1_key(p1_key), .p2_key(p2_key),
    .p1_id(p1_id), .p2_id(p2_id),
    .p1_hp(p1_hp), .p1_speed(p1_speed), .p1_dmg1(p1_dmg1), .p1_dmg2(p1_dmg2), .p1_dmg3(p1_dmg3),
    .p2_hp(p2_hp), .p2_speed(p2_speed), .p2_dmg1(p2_dmg1), .p2_dmg2(p2_dmg2), .p2_dmg3(p2_dmg3),
    .p1_locked(p1_locked), .p2_locked(p2_locked), .choose_done(choose_done)
  );

  always #5 clk = ~clk;

  // expected record {id1,id2,hp1,spd1,hp2,spd2,lock1,lock2,done}
  function automatic logic [50:0] ex(int i1, int i2, int l1, int l2, int dn);
    return {8'(i1), 8'(i2), 8'(hp_tab[i1-1]), 8'(spd_tab[i1-1]),
            8'(hp_tab[i2-1]), 8'(spd_tab[i2-1]), 1'(l1), 1'(l2), 1'(dn)};
  endfunction

  function automatic vec_t mk(logic [3:0] sc, logic [4:0] k1, logic [4:0] k2,
                              int i1, int i2, int l1, int l2, int dn);
    vec_t v;
    v.sc = sc; v.k1 = k1; v.k2 = k2;
    v.exp = ex(i1, i2, l1, l2, dn);
    return v;
  endfunction

  function automatic logic [50:0] got();
    return {p1_id, p2_id, p1_hp, p1_speed, p2_hp, p2_speed, p1_locked, p2_locked, choose_done};
  endfunction

  task automatic check(input string nm, input logic [50:0] g, input logic [50:0] e);
    tests_run++;
    if (g !== e) begin
      tests_failed++;
      $display("FAIL %s: got id1=%0d id2=%0d hp1=%0d sp1=%0d hp2=%0d sp2=%0d lk=%b%b done=%b, expected id1=%0d id2=%0d hp1=%0d sp1=%0d hp2=%0d sp2=%0d lk=%b%b done=%b",
               nm, g[50:43], g[42:35], g[34:27], g[26:19], g[18:11], g[10:3], g[2], g[1], g[0],
               e[50:43], e[42:35], e[34:27], e[26:19], e[18:11], e[10:3], e[2], e[1], e[0]);
    end
  endtask

  // one clock with key pulses held across exactly one rising edge
  task automatic cyc(input logic [3:0] sc, input logic [4:0] k1, input logic [4:0] k2);
    scene_state = sc; p1_key = k1; p2_key = k2;
    @(posedge clk);
    #1;
    p1_key = 5'd0; p2_key = 5'd0;
  endtask

  initial begin
    reset = 1'b1; scene_state = 4'd0; p1_key = 5'd0; p2_key = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_state", got(), ex(1, 8, 0, 0, 0));

    tests_run++;
    if ({p1_dmg1, p1_dmg2, p1_dmg3, p2_dmg1, p2_dmg2, p2_dmg3} !== {8'd30, 8'd40, 8'd50, 8'd30, 8'd40, 8'd50}) begin
      tests_failed++;
      $display("FAIL dmg: got %0d %0d %0d / %0d %0d %0d expected 30 40 50 / 30 40 50",
               p1_dmg1, p1_dmg2, p1_dmg3, p2_dmg1, p2_dmg2, p2_dmg3);
    end

    vecs.push_back(mk(2, 0,  0,  1, 8, 0, 0, 0));
    vecs.push_back(mk(2, KR, 0,  2, 8, 0, 0, 0));
    vecs.push_back(mk(2, KR, 0,  3, 8, 0, 0, 0));
    vecs.push_back(mk(2, KD, 0,  7, 8, 0, 0, 0));
    vecs.push_back(mk(2, KU, 0,  3, 8, 0, 0, 0));
    vecs.push_back(mk(2, KR, 0,  4, 8, 0, 0, 0));
    vecs.push_back(mk(2, KR, 0,  WRAP ? 1 : 4, 8, 0, 0, 0));
    vecs.push_back(mk(1, 0,  0,  1, 8, 0, 0, 0));
    vecs.push_back(mk(2, KU, KD, WRAP ? 5 : 1, WRAP ? 4 : 8, 0, 0, 0));
    vecs.push_back(mk(1, 0,  0,  1, 8, 0, 0, 0));
    vecs.push_back(mk(2, 0,  KL, 1, 7, 0, 0, 0));
    vecs.push_back(mk(2, KC, 0,  1, 7, 1, 0, 0));
    vecs.push_back(mk(2, KR, 0,  1, 7, 1, 0, 0));
    vecs.push_back(mk(2, KC, 0,  1, 7, 0, 0, 0));
    vecs.push_back(mk(2, KR, 0,  2, 7, 0, 0, 0));
    vecs.push_back(mk(2, 5'b10010, 0, 2, 7, 0, 0, 0));
    vecs.push_back(mk(3, KR, KL, 2, 7, 0, 0, 0));
    vecs.push_back(mk(2, KC, KC, 2, 7, 1, 1, 1));
    vecs.push_back(mk(2, 0,  0,  2, 7, 1, 1, 0));
    vecs.push_back(mk(2, KC, KD, 2, 7, 1, 1, 0));
    vecs.push_back(mk(1, 0,  0,  1, 8, 0, 0, 0));
    vecs.push_back(mk(2, KC, 0,  1, 8, 1, 0, 0));
    vecs.push_back(mk(2, 0,  KC, 1, 8, 1, 1, 1));
    vecs.push_back(mk(2, 0,  0,  1, 8, 1, 1, 0));
    vecs.push_back(mk(1, 0,  0,  1, 8, 0, 0, 0));

    foreach (vecs[i]) begin
      cyc(vecs[i].sc, vecs[i].k1, vecs[i].k2);
      check($sformatf("vec%0d", i), got(), vecs[i].exp);
    end

    // synchronous reset wins over a concurrent key
    cyc(2, KR, 0);
    check("pre_reset_move", got(), ex(2, 8, 0, 0, 0));
    reset = 1'b1;
    cyc(2, KR, 0);
    reset = 1'b0;
    check("reset_mid_browse", got(), ex(1, 8, 0, 0, 0));

    // DONE survives a scene hold and ignores keys after returning to choose
    cyc(2, KC, KC);
    check("done_pulse", got(), ex(1, 8, 1, 1, 1));
    cyc(3, 0, 0);
    check("done_hold_scene3", got(), ex(1, 8, 1, 1, 0));
    cyc(2, KC, KU);
    check("done_keys_ignored", got(), ex(1, 8, 1, 1, 0));
    cyc(1, 0, 0);
    check("scene1_clears_done", got(), ex(1, 8, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
